// File: rtl/aes_pkg.sv
// Shared constants, state codes and helper types for the AES host controller.
package aes_pkg;

    localparam int KEY_WORDS = 60;
    localparam int MAX_WORDS = 16;
    localparam int TIMEOUT   = 255;

    localparam logic [1:0] MODE_ENC  = 2'd1;
    localparam logic [1:0] MODE_DEC  = 2'd2;
    localparam logic [2:0] CORE_DONE = 3'b111;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_KEY  = 3'd1;
    localparam logic [2:0] S_LOAD_DATA = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_RD_ADDR   = 3'd5;
    localparam logic [2:0] S_RD_CAP    = 3'd6;
    localparam logic [2:0] S_RD_OUT    = 3'd7;

    // One registered write slot shared by the key and data BRAM ports.
    typedef struct packed {
        logic        vld;
        logic        isKey;
        logic [8:0]  addr;
        logic [31:0] dat;
    } wrPipe_t;

    function automatic logic cmdOk(input logic [1:0] mode, input logic [8:0] len,
                                   input logic [8:0] maxWords);
        return ((mode == MODE_ENC) || (mode == MODE_DEC)) && (len != 9'd0) &&
               (len[1:0] == 2'b00) && (len <= maxWords);
    endfunction

endpackage

// File: rtl/aes_host_ctrl_if.sv
// Host/core/BRAM signal bundle for aes_host_ctrl; slave is the controller side.
interface aes_host_ctrl_if;

    logic        cmdValidIn;
    logic        cmdReadyOut;
    logic [1:0]  cmdModeIn;
    logic [8:0]  cmdLenIn;

    logic [31:0] keyWordIn;
    logic        keyValidIn;
    logic        keyReadyOut;

    logic [31:0] dataWordIn;
    logic        dataValidIn;
    logic        dataReadyOut;

    logic [7:0]  keyMemAddrOut;
    logic [31:0] keyMemDataOut;
    logic [3:0]  keyMemWeOut;

    logic [8:0]  dataMemAddrOut;
    logic [31:0] dataMemDataOut;
    logic [3:0]  dataMemWeOut;

    logic [1:0]  coreStartOut;
    logic [8:0]  coreLengthOut;
    logic [2:0]  coreDoneIn;

    logic [8:0]  resMemAddrOut;
    logic [31:0] resMemDataIn;

    logic [31:0] resWordOut;
    logic        resValidOut;
    logic        resReadyIn;

    logic        busyOut;
    logic        errOut;

    modport slave (
        input  cmdValidIn, cmdModeIn, cmdLenIn,
        input  keyWordIn, keyValidIn, dataWordIn, dataValidIn,
        input  coreDoneIn, resMemDataIn, resReadyIn,
        output cmdReadyOut, keyReadyOut, dataReadyOut,
        output keyMemAddrOut, keyMemDataOut, keyMemWeOut,
        output dataMemAddrOut, dataMemDataOut, dataMemWeOut,
        output coreStartOut, coreLengthOut, resMemAddrOut,
        output resWordOut, resValidOut, busyOut, errOut
    );

    modport master (
        output cmdValidIn, cmdModeIn, cmdLenIn,
        output keyWordIn, keyValidIn, dataWordIn, dataValidIn,
        output coreDoneIn, resMemDataIn, resReadyIn,
        input  cmdReadyOut, keyReadyOut, dataReadyOut,
        input  keyMemAddrOut, keyMemDataOut, keyMemWeOut,
        input  dataMemAddrOut, dataMemDataOut, dataMemWeOut,
        input  coreStartOut, coreLengthOut, resMemAddrOut,
        input  resWordOut, resValidOut, busyOut, errOut
    );

endinterface

// File: rtl/aes_host_ctrl.sv
// Sequences one AES job: key and data into BRAM (writes land 1 cycle after each handshake), core start/wait, results out.
// Results take at least 3 cycles per word; resWordOut holds while resReadyIn is low, loads stall on valid/ready.
module aes_host_ctrl #(
    parameter int KEY_WORDS = aes_pkg::KEY_WORDS,
    parameter int MAX_WORDS = aes_pkg::MAX_WORDS,
    parameter int TIMEOUT   = aes_pkg::TIMEOUT
) (
    input  logic             clkIn,
    input  logic             resetIn,
    aes_host_ctrl_if.slave   bus
);

    import aes_pkg::*;

    logic [2:0]  state;
    logic [1:0]  modeReg;
    logic [8:0]  lenReg;
    logic [8:0]  wordCnt;
    logic [15:0] timer;
    logic [31:0] resWord;
    logic        errReg;
    wrPipe_t     pipe;

    logic keyHs;
    logic dataHs;
    logic cmdGood;
    logic lastKey;
    logic lastWord;
    logic coreActive;
    logic rdPhase;

    assign cmdGood    = cmdOk(bus.cmdModeIn, bus.cmdLenIn, 9'(MAX_WORDS));
    assign keyHs      = (state == S_LOAD_KEY)  && bus.keyValidIn;
    assign dataHs     = (state == S_LOAD_DATA) && bus.dataValidIn;
    assign lastKey    = (wordCnt == 9'(KEY_WORDS - 1));
    assign lastWord   = (wordCnt == (lenReg - 9'd1));
    assign coreActive = (state == S_START) || (state == S_WAIT_DONE);
    assign rdPhase    = (state == S_RD_ADDR) || (state == S_RD_CAP) || (state == S_RD_OUT);

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            state   <= S_IDLE;
            modeReg <= 2'd0;
            lenReg  <= 9'd0;
            wordCnt <= 9'd0;
            timer   <= 16'd0;
            resWord <= 32'd0;
            errReg  <= 1'b0;
            pipe    <= '0;
        end else begin
            // Key and data writes go through the same slot, one cycle behind the handshake.
            pipe.vld   <= keyHs || dataHs;
            pipe.isKey <= keyHs;
            if (keyHs || dataHs) begin
                pipe.addr <= wordCnt;
                pipe.dat  <= keyHs ? bus.keyWordIn : bus.dataWordIn;
            end

            case (state)
                S_IDLE: begin
                    if (bus.cmdValidIn) begin
                        if (cmdGood) begin
                            modeReg <= bus.cmdModeIn;
                            lenReg  <= bus.cmdLenIn;
                            errReg  <= 1'b0;
                            wordCnt <= 9'd0;
                            state   <= S_LOAD_KEY;
                        end else begin
                            errReg  <= 1'b1;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (keyHs) begin
                        if (lastKey) begin
                            wordCnt <= 9'd0;
                            state   <= S_LOAD_DATA;
                        end else begin
                            wordCnt <= wordCnt + 9'd1;
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (dataHs) begin
                        if (lastWord) begin
                            wordCnt <= 9'd0;
                            state   <= S_START;
                        end else begin
                            wordCnt <= wordCnt + 9'd1;
                        end
                    end
                end
                S_START: begin
                    timer <= 16'd0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (bus.coreDoneIn == CORE_DONE) begin
                        state <= S_RD_ADDR;
                    end else if (timer == 16'(TIMEOUT - 1)) begin
                        errReg <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    resWord <= bus.resMemDataIn;
                    state   <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (bus.resReadyIn) begin
                        if (lastWord) begin
                            wordCnt <= 9'd0;
                            state   <= S_IDLE;
                        end else begin
                            wordCnt <= wordCnt + 9'd1;
                            state   <= S_RD_ADDR;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmdReadyOut    = (state == S_IDLE);
    assign bus.keyReadyOut    = (state == S_LOAD_KEY);
    assign bus.dataReadyOut   = (state == S_LOAD_DATA);

    assign bus.keyMemAddrOut  = pipe.addr[7:0];
    assign bus.keyMemDataOut  = pipe.dat;
    assign bus.keyMemWeOut    = (pipe.vld && pipe.isKey)  ? 4'hF : 4'h0;
    assign bus.dataMemAddrOut = pipe.addr;
    assign bus.dataMemDataOut = pipe.dat;
    assign bus.dataMemWeOut   = (pipe.vld && !pipe.isKey) ? 4'hF : 4'h0;

    assign bus.coreStartOut   = coreActive ? modeReg : 2'd0;
    assign bus.coreLengthOut  = lenReg;
    assign bus.resMemAddrOut  = rdPhase ? wordCnt : 9'd0;

    assign bus.resWordOut     = resWord;
    assign bus.resValidOut    = (state == S_RD_OUT);
    assign bus.busyOut        = (state != S_IDLE);
    assign bus.errOut         = errReg;

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Directed scoreboard bench for aes_host_ctrl with a behavioural core and result BRAM.
`timescale 1ns/1ps
module tb_aes_host_ctrl;

    import aes_pkg::*;

    logic clkIn = 1'b0;
    logic resetIn;

    aes_host_ctrl_if bus();

    aes_host_ctrl #(
        .KEY_WORDS(KEY_WORDS),
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clkIn  (clkIn),
        .resetIn(resetIn),
        .bus    (bus)
    );

    always #5 clkIn = ~clkIn;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] keySched [60];
    logic [31:0] pt [4];
    logic [31:0] ct [4];
    logic [31:0] resMem [0:15];
    logic [31:0] expQ [$];
    logic [44:0] keyLog [$];
    logic [44:0] dataLog [$];
    logic [31:0] srcLog [$];

    // Result BRAM: one-cycle registered read.
    always @(posedge clkIn) bus.resMemDataIn <= resMem[bus.resMemAddrOut[3:0]];

    always @(negedge clkIn) begin
        if (bus.keyMemWeOut != 4'h0)
            keyLog.push_back({bus.keyMemWeOut, 1'b0, bus.keyMemAddrOut, bus.keyMemDataOut});
        if (bus.dataMemWeOut != 4'h0)
            dataLog.push_back({bus.dataMemWeOut, bus.dataMemAddrOut, bus.dataMemDataOut});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic buildKeySchedule();
        logic [7:0]  rcon = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) keySched[i] = 32'h00010203 + 32'(i) * 32'h04040404;
        for (int i = 8; i < 60; i++) begin
            t = keySched[i-1];
            if (i % 8 == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = subWord(t);
            end
            keySched[i] = keySched[i-8] ^ t;
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_cmdRdy"},  bus.cmdReadyOut, 1);
        check({tag, "_busy"},    bus.busyOut, 0);
        check({tag, "_err"},     bus.errOut, 0);
        check({tag, "_rdys"},    {bus.keyReadyOut, bus.dataReadyOut, bus.resValidOut}, 0);
        check({tag, "_we"},      {bus.keyMemWeOut, bus.dataMemWeOut}, 0);
        check({tag, "_addr"},    {bus.keyMemAddrOut, bus.dataMemAddrOut, bus.resMemAddrOut}, 0);
        check({tag, "_wdata"},   {bus.keyMemDataOut, bus.dataMemDataOut}, 0);
        check({tag, "_core"},    {bus.coreStartOut, bus.coreLengthOut}, 0);
        check({tag, "_resWord"}, bus.resWordOut, 0);
    endtask

    task automatic sendCmd(input logic [1:0] mode, input logic [8:0] len);
        bus.cmdValidIn = 1'b1;
        bus.cmdModeIn  = mode;
        bus.cmdLenIn   = len;
        @(negedge clkIn);
        bus.cmdValidIn = 1'b0;
    endtask

    task automatic sendWord(input bit isKey, input logic [31:0] w);
        int cyc = 0;
        if (isKey) begin bus.keyValidIn  = 1'b1; bus.keyWordIn  = w; end
        else       begin bus.dataValidIn = 1'b1; bus.dataWordIn = w; end
        while (((isKey && !bus.keyReadyOut) || (!isKey && !bus.dataReadyOut)) && cyc < 50) begin
            @(negedge clkIn);
            cyc++;
        end
        check(isKey ? "key_ready_wait" : "data_ready_wait", 64'(cyc < 50), 1);
        @(negedge clkIn);
        bus.keyValidIn  = 1'b0;
        bus.dataValidIn = 1'b0;
    endtask

    task automatic loadJob(input logic [1:0] mode, input int len, input bit pushExp);
        logic [31:0] src;
        keyLog.delete(); dataLog.delete(); srcLog.delete();
        sendCmd(mode, 9'(len));
        check("accept_busy", bus.busyOut, 1);
        check("accept_err_clear", bus.errOut, 0);
        check("busy_cmd_ready", bus.cmdReadyOut, 0);
        // A malformed command while busy must be ignored.
        bus.cmdValidIn = 1'b1; bus.cmdModeIn = 2'd3; bus.cmdLenIn = 9'd0;
        for (int k = 0; k < 60; k++) sendWord(1'b1, keySched[k]);
        bus.cmdValidIn = 1'b0;
        check("busy_cmd_ignored", bus.errOut, 0);
        for (int k = 0; k < len; k++) begin
            src = (mode == MODE_ENC) ? pt[k % 4] : ct[k % 4];
            srcLog.push_back(src);
            sendWord(1'b0, src);
            if (pushExp) expQ.push_back((mode == MODE_ENC) ? ct[k % 4] : pt[k % 4]);
        end
    endtask

    task automatic runJob(input logic [1:0] mode, input int len, input int stallIdx);
        int cyc;
        logic [31:0] held;
        loadJob(mode, len, 1'b1);
        cyc = 0;
        while (bus.coreStartOut == 2'd0 && cyc < 20) begin @(negedge clkIn); cyc++; end
        check("core_start_mode", bus.coreStartOut, mode);
        check("core_length", bus.coreLengthOut, 64'(len));
        for (int k = 0; k < len; k++) resMem[k] = (mode == MODE_ENC) ? ct[k % 4] : pt[k % 4];
        repeat (3) @(negedge clkIn);
        check("core_start_hold", bus.coreStartOut, mode);
        bus.coreDoneIn = CORE_DONE;
        @(negedge clkIn);
        bus.coreDoneIn = 3'b000;
        check("core_start_clear", bus.coreStartOut, 0);
        bus.resReadyIn = 1'b1;
        for (int k = 0; k < len; k++) begin
            cyc = 0;
            while (!bus.resValidOut && cyc < 20) begin @(negedge clkIn); cyc++; end
            check("res_gap_cycles", 64'(cyc), 2);
            if (k == stallIdx) begin
                bus.resReadyIn = 1'b0;
                held = bus.resWordOut;
                repeat (10) begin
                    @(negedge clkIn);
                    check("stall_valid_held", bus.resValidOut, 1);
                    check("stall_word_stable", bus.resWordOut, held);
                end
                bus.resReadyIn = 1'b1;
            end
            if (expQ.size() > 0) check("res_word", bus.resWordOut, expQ.pop_front());
            else check("res_unexpected", 0, 1);
            @(negedge clkIn);
        end
        check("job_end_idle", {bus.busyOut, bus.cmdReadyOut, bus.resValidOut}, 3'b010);
        check("scoreboard_empty", 64'(expQ.size()), 0);
        check("key_wr_count", 64'(keyLog.size()), 60);
        for (int k = 0; k < keyLog.size() && k < 60; k++)
            check("key_wr", keyLog[k], {4'hF, 1'b0, 8'(k), keySched[k]});
        check("data_wr_count", 64'(dataLog.size()), 64'(len));
        for (int k = 0; k < dataLog.size() && k < len; k++)
            check("data_wr", dataLog[k], {4'hF, 9'(k), srcLog[k]});
    endtask

    task automatic badCmd(input logic [1:0] mode, input logic [8:0] len);
        keyLog.delete(); dataLog.delete();
        sendCmd(mode, len);
        check("bad_cmd_err", bus.errOut, 1);
        check("bad_cmd_busy", bus.busyOut, 0);
        repeat (3) @(negedge clkIn);
        check("bad_cmd_idle", {bus.busyOut, bus.cmdReadyOut}, 2'b01);
        check("bad_cmd_no_writes", 64'(keyLog.size() + dataLog.size()), 0);
    endtask

    initial begin
        pt = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        ct = '{32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089};
        buildKeySchedule();
        resetIn = 1'b0;
        bus.cmdValidIn = 1'b0; bus.cmdModeIn = 2'd0; bus.cmdLenIn = 9'd0;
        bus.keyValidIn = 1'b0; bus.keyWordIn = 32'd0;
        bus.dataValidIn = 1'b0; bus.dataWordIn = 32'd0;
        bus.coreDoneIn = 3'b000; bus.resReadyIn = 1'b0;
        for (int k = 0; k < 16; k++) resMem[k] = 32'd0;
        repeat (3) @(negedge clkIn);
        checkResetState("reset");
        resetIn = 1'b1;
        @(negedge clkIn);

        runJob(MODE_ENC, 16, -1);
        runJob(MODE_DEC, 4, -1);

        badCmd(MODE_ENC, 9'd6);
        badCmd(2'd3, 9'd4);
        badCmd(MODE_ENC, 9'd0);
        badCmd(MODE_DEC, 9'd20);

        runJob(MODE_ENC, 8, 2);

        // Core never reports done.
        begin
            int cyc = 0;
            loadJob(MODE_ENC, 4, 1'b0);
            while (bus.coreStartOut == 2'd0 && cyc < 20) begin @(negedge clkIn); cyc++; end
            check("to_start_seen", bus.coreStartOut, MODE_ENC);
            @(negedge clkIn);
            repeat (TIMEOUT - 1) @(negedge clkIn);
            check("to_err_early", bus.errOut, 0);
            check("to_start_held", bus.coreStartOut, MODE_ENC);
            @(negedge clkIn);
            check("to_err", bus.errOut, 1);
            check("to_start_clear", bus.coreStartOut, 0);
            check("to_idle", {bus.busyOut, bus.cmdReadyOut}, 2'b01);
        end

        // Reset in the middle of the data load.
        sendCmd(MODE_ENC, 9'd16);
        for (int k = 0; k < 60; k++) sendWord(1'b1, keySched[k]);
        for (int k = 0; k < 5; k++) sendWord(1'b0, pt[k % 4]);
        bus.dataValidIn = 1'b1;
        bus.dataWordIn  = pt[1];
        resetIn = 1'b0;
        @(negedge clkIn);
        resetIn = 1'b1;
        bus.dataValidIn = 1'b0;
        checkResetState("midjob_reset");
        @(negedge clkIn);
        runJob(MODE_DEC, 4, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/aes_host_ctrl.md
AES_HOST_CTRL -- requirements
Module: aes_host_ctrl

Interface
REQ-001 Parameters, one per line: KEY_WORDS, 60, expanded-key words written per job; MAX_WORDS, 16, maximum data words per job; TIMEOUT, 255, WAIT_DONE cycle limit.
REQ-002 clkIn  in  1  sole clock; all logic on rising edge.
REQ-003 resetIn  in  1  synchronous, active-low reset.
REQ-004 cmdValidIn / cmdReadyOut  in/out  1/1  job command handshake.
REQ-005 cmdModeIn  in  2  job mode: 1 encrypt, 2 decrypt.
REQ-006 cmdLenIn  in  9  job data length in 32-bit words.
REQ-007 keyWordIn, keyValidIn / keyReadyOut  in, in/out  32, 1/1  expanded-key stream, first word = round-0 MSW.
REQ-008 dataWordIn, dataValidIn / dataReadyOut  in, in/out  32, 1/1  plaintext/ciphertext stream.
REQ-009 keyMemAddrOut, keyMemDataOut, keyMemWeOut  out  8, 32, 4  key BRAM write port.
REQ-010 dataMemAddrOut, dataMemDataOut, dataMemWeOut  out  9, 32, 4  data BRAM write port.
REQ-011 coreStartOut, coreLengthOut  out  2, 9  core start level and length.
REQ-012 coreDoneIn  in  3  core completion; 3'b111 = done.
REQ-013 resMemAddrOut, resMemDataIn  out, in  9, 32  result BRAM read port, 1-cycle read latency.
REQ-014 resWordOut, resValidOut / resReadyIn  out, out/in  32, 1/1  result stream.
REQ-015 busyOut, errOut  out  1, 1  job in progress; sticky job error.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_KEY, LOAD_DATA, START, WAIT_DONE, RD_ADDR, RD_CAP, RD_OUT.
REQ-017 IDLE: cmdReadyOut=1; on cmdValidIn, cmdModeIn in {1,2}, cmdLenIn nonzero, multiple of 4, <=MAX_WORDS -> latch mode/len, clear errOut, go LOAD_KEY; otherwise errOut=1 next cycle, stay IDLE.
REQ-018 LOAD_KEY: keyReadyOut=1; each key handshake SHALL produce, next cycle, keyMemWeOut=4'hF, keyMemDataOut=word, keyMemAddrOut=0..KEY_WORDS-1 incrementing; after word KEY_WORDS-1 -> LOAD_DATA.
REQ-019 LOAD_DATA: dataReadyOut=1; same one-cycle-delayed write on data port, addresses 0..len-1; after word len-1 -> START.
REQ-020 Write enables SHALL be 4'h0 in every cycle without a preceding handshake; keyReadyOut/dataReadyOut SHALL be 0 outside their states.
REQ-021 START: one cycle, coreStartOut=latched mode, coreLengthOut=len; -> WAIT_DONE.
REQ-022 WAIT_DONE: coreStartOut SHALL hold mode; on coreDoneIn==3'b111 -> coreStartOut=0, RD_ADDR; cycle counter reaching TIMEOUT -> errOut=1, coreStartOut=0, IDLE.
REQ-023 RD_ADDR drives resMemAddrOut=index (0..len-1); RD_CAP registers resMemDataIn into resWordOut; RD_OUT asserts resValidOut until resReadyIn.
REQ-024 resWordOut SHALL be stable while resValidOut=1 and resReadyIn=0.
REQ-025 RD_OUT handshake: last index -> IDLE, else index+1, RD_ADDR; minimum 3 cycles per result word.
REQ-026 busyOut SHALL be 1 in every state except IDLE.
REQ-027 Word counters SHALL be 9 bits wide, compare against latched len/KEY_WORDS, never wrap.
REQ-028 cmdValidIn while busy SHALL be ignored (cmdReadyOut=0).

Reset
REQ-029 resetIn low at a clock edge SHALL force IDLE in any state, including mid-job.
REQ-030 Reset values: cmdReadyOut=1 (IDLE), all ready/valid/we/start/busy/err outputs 0, coreLengthOut=0, all address and data outputs 0.

Structure
REQ-031 State encoding, KEY_WORDS, MAX_WORDS, TIMEOUT, mode codes (1/2) and done code 3'b111 SHALL live in shared package aes_pkg.
REQ-032 Single module; no sub-module; key and data write paths share one registered write-pipe pattern.

Verification
REQ-033 Encrypt, len=16, FIPS-197 AES-256 key schedule and plaintext 00112233..ff x4 -> 60 key writes addr 0..59, 16 data writes, coreStartOut=1, result 8ea2b7ca516745bfeafc49904b496089 x4.
REQ-034 Decrypt, len=4, ciphertext 8ea2b7ca...6089 -> coreStartOut=2, result 00112233445566778899aabbccddeeff.
REQ-035 Command len=6, mode=3, or len=0 -> errOut=1, busyOut stays 0, no memory writes.
REQ-036 coreDoneIn held 0 -> errOut=1 exactly TIMEOUT cycles after WAIT_DONE entry, coreStartOut=0, IDLE.
REQ-037 resReadyIn low for 10 cycles on word 2 -> resWordOut unchanged, resValidOut held, no word lost or duplicated.
REQ-038 resetIn low during LOAD_DATA at word 5 -> next cycle IDLE, all outputs at reset values; fresh job then completes correctly.
